// File: rtl/axi_reg_init_pkg.sv
// ============================================================================
//  Module      : axi_reg_init_pkg
//  Description : Shared types and constants for the AXI register initiator.
//                State encoding, AXI response codes and fixed-field helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_reg_init_pkg;

    // Initiator state machine encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_RSP     = 3'd6
    } state_e;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AXI burst type used for every access
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // AxSIZE encoding for a full-width beat of the given data bus width
    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_reg_initiator_if.sv
// ============================================================================
//  Module      : axi_reg_initiator_if
//  Description : Command/response handshake plus the AXI4 master channels of
//                the register initiator. "master" is the initiator view,
//                "slave" is the view of the command source / AXI target.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_reg_initiator_if #(
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 1
);
    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

    // Command / response side
    logic                      cmd_valid, cmd_ready, cmd_write;
    logic [AXI_ADDR_WIDTH-1:0] cmd_addr;
    logic [AXI_DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0]     cmd_wstrb;
    logic                      rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [AXI_DATA_WIDTH-1:0] rsp_rdata;

    // AXI write address channel
    logic [AXI_ID_WIDTH-1:0]   m_axi_awid;
    logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [7:0]                m_axi_awlen;
    logic [2:0]                m_axi_awsize;
    logic [1:0]                m_axi_awburst;
    logic                      m_axi_awlock;
    logic [3:0]                m_axi_awcache, m_axi_awqos, m_axi_awregion;
    logic [2:0]                m_axi_awprot;
    logic [AXI_USER_WIDTH-1:0] m_axi_awuser;
    logic                      m_axi_awvalid, m_axi_awready;
    // AXI write data channel
    logic [AXI_DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_WIDTH-1:0]     m_axi_wstrb;
    logic                      m_axi_wlast;
    logic [AXI_USER_WIDTH-1:0] m_axi_wuser;
    logic                      m_axi_wvalid, m_axi_wready;
    // AXI write response channel
    logic [AXI_ID_WIDTH-1:0]   m_axi_bid;
    logic [1:0]                m_axi_bresp;
    logic [AXI_USER_WIDTH-1:0] m_axi_buser;
    logic                      m_axi_bvalid, m_axi_bready;
    // AXI read address channel
    logic [AXI_ID_WIDTH-1:0]   m_axi_arid;
    logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]                m_axi_arlen;
    logic [2:0]                m_axi_arsize;
    logic [1:0]                m_axi_arburst;
    logic                      m_axi_arlock;
    logic [3:0]                m_axi_arcache, m_axi_arqos, m_axi_arregion;
    logic [2:0]                m_axi_arprot;
    logic [AXI_USER_WIDTH-1:0] m_axi_aruser;
    logic                      m_axi_arvalid, m_axi_arready;
    // AXI read data channel
    logic [AXI_ID_WIDTH-1:0]   m_axi_rid;
    logic [AXI_DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]                m_axi_rresp;
    logic                      m_axi_rlast;
    logic [AXI_USER_WIDTH-1:0] m_axi_ruser;
    logic                      m_axi_rvalid, m_axi_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion,
               m_axi_awuser, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_buser, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion,
               m_axi_aruser, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion,
               m_axi_awuser, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_buser, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion,
               m_axi_aruser, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser, m_axi_rvalid,
        input  m_axi_rready
    );

endinterface

`default_nettype wire

// File: rtl/axi_reg_init_timeout.sv
// ============================================================================
//  Module      : axi_reg_init_timeout
//  Description : 16-bit response-wait counter with terminal compare. Only
//                instantiated when AXI_REG_INIT_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_reg_init_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic aclk,
    input  wire logic areset,
    input  wire logic clear,    // entering a response-wait state
    input  wire logic run,      // currently in a response-wait state
    output logic      expired   // this wait cycle is the last one allowed
);
    logic [15:0] cnt_q, cnt_d;

    // Counter restarts on entry to a wait state and advances while waiting
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count reaches the limit on the edge that closes this cycle
    assign expired = run && ((cnt_q + 16'd1) == 16'(TIMEOUT_CYCLES));

endmodule

`default_nettype wire

// File: rtl/axi_reg_initiator.sv
// ============================================================================
//  Module      : axi_reg_initiator
//  Description : Single-beat AXI4 register initiator. Accepts one command at
//                a time, issues one AW+W or AR beat, waits for B or R and
//                returns a response. Define AXI_REG_INIT_TIMEOUT_EN to bound
//                the response wait and drain one late beat after a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_reg_initiator
    import axi_reg_init_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 1,
    parameter int AXI_ID         = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input wire logic            aclk,
    input wire logic            areset,
    axi_reg_initiator_if.master bus
);
    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
    logic                      is_write_q, is_write_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      arvalid_q, arvalid_d;
    logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
    logic                      timeout_hit;

`ifdef AXI_REG_INIT_TIMEOUT_EN
    logic wait_run, wait_entry;
    assign wait_run   = (state_q == ST_WR_RESP) || (state_q == ST_RD_RESP);
    assign wait_entry = !wait_run && ((state_d == ST_WR_RESP) || (state_d == ST_RD_RESP));

    axi_reg_init_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .aclk    (aclk),
        .areset  (areset),
        .clear   (wait_entry),
        .run     (wait_run),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and datapath: capture command, track each request channel, collect response
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        is_write_d    = is_write_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d        = bus.cmd_addr;
                    wdata_d       = bus.cmd_wdata;
                    wstrb_d       = bus.cmd_wstrb;
                    is_write_d    = bus.cmd_write;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    if (bus.cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently; move on once both are done
                if (awvalid_q && bus.m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && bus.m_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)        state_d   = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                // A beat in the final wait cycle takes precedence over the timeout
                if (bus.m_axi_bvalid) begin
                    rsp_err_d = bus.m_axi_bresp[1];
                    state_d   = ST_RSP;
                end else if (timeout_hit) begin
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                if (bus.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (bus.m_axi_rvalid) begin
                    rsp_rdata_d = bus.m_axi_rdata;
                    rsp_err_d   = bus.m_axi_rresp[1];
                    state_d     = ST_RSP;
                end else if (timeout_hit) begin
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RSP;
                end
            end
            ST_RSP: begin
                // After a timeout the outstanding beat still has to be absorbed
                if (bus.rsp_ready) state_d = rsp_timeout_q ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (is_write_q ? bus.m_axi_bvalid : bus.m_axi_rvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            is_write_q    <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            is_write_q    <= is_write_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Command/response handshake; cmd_ready is masked while reset is held
    assign bus.cmd_ready   = (state_q == ST_IDLE) && !areset;
    assign bus.rsp_valid   = (state_q == ST_RSP);
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

    // Write address / data channels: single INCR beat, all side fields zero
    assign bus.m_axi_awid     = AXI_ID_WIDTH'(AXI_ID);
    assign bus.m_axi_awaddr   = addr_q;
    assign bus.m_axi_awlen    = 8'd0;
    assign bus.m_axi_awsize   = axi_size(AXI_DATA_WIDTH);
    assign bus.m_axi_awburst  = BURST_INCR;
    assign bus.m_axi_awlock   = 1'b0;
    assign bus.m_axi_awcache  = 4'd0;
    assign bus.m_axi_awprot   = 3'd0;
    assign bus.m_axi_awqos    = 4'd0;
    assign bus.m_axi_awregion = 4'd0;
    assign bus.m_axi_awuser   = '0;
    assign bus.m_axi_awvalid  = awvalid_q;
    assign bus.m_axi_wdata    = wdata_q;
    assign bus.m_axi_wstrb    = wstrb_q;
    assign bus.m_axi_wlast    = 1'b1;
    assign bus.m_axi_wuser    = '0;
    assign bus.m_axi_wvalid   = wvalid_q;

    // Read address channel
    assign bus.m_axi_arid     = AXI_ID_WIDTH'(AXI_ID);
    assign bus.m_axi_araddr   = addr_q;
    assign bus.m_axi_arlen    = 8'd0;
    assign bus.m_axi_arsize   = axi_size(AXI_DATA_WIDTH);
    assign bus.m_axi_arburst  = BURST_INCR;
    assign bus.m_axi_arlock   = 1'b0;
    assign bus.m_axi_arcache  = 4'd0;
    assign bus.m_axi_arprot   = 3'd0;
    assign bus.m_axi_arqos    = 4'd0;
    assign bus.m_axi_arregion = 4'd0;
    assign bus.m_axi_aruser   = '0;
    assign bus.m_axi_arvalid  = arvalid_q;

    // Responses are only accepted while one is expected
    assign bus.m_axi_bready = (state_q == ST_WR_RESP) || ((state_q == ST_DRAIN) && is_write_q);
    assign bus.m_axi_rready = (state_q == ST_RD_RESP) || ((state_q == ST_DRAIN) && !is_write_q);

    // Response-side fields that carry no information for a single-beat initiator
    logic unused_inputs;
    assign unused_inputs = ^{bus.m_axi_bid, bus.m_axi_buser, bus.m_axi_bresp[0],
                             bus.m_axi_rid, bus.m_axi_ruser, bus.m_axi_rresp[0],
                             bus.m_axi_rlast, 16'(TIMEOUT_CYCLES)};

endmodule

`default_nettype wire

// File: tb/tb_axi_reg_initiator.sv
// ============================================================================
//  Module      : tb_axi_reg_initiator
//  Description : Directed self-checking bench for axi_reg_initiator. The
//                timeout scenarios run only when AXI_REG_INIT_TIMEOUT_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_reg_initiator;
    import axi_reg_init_pkg::*;

    localparam int IDW = 10;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int UW  = 1;
    localparam int TO  = 8;

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axi_reg_initiator_if #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW),
                           .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW)) bus ();

    axi_reg_initiator #(
        .AXI_ID_WIDTH   (IDW),
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .AXI_USER_WIDTH (UW),
        .AXI_ID         (0),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus.master)
    );

    int checks   = 0;
    int failures = 0;
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

    // Handshake counters on each AXI channel
    always @(posedge aclk) begin
        if (bus.m_axi_awvalid && bus.m_axi_awready) n_aw <= n_aw + 1;
        if (bus.m_axi_wvalid  && bus.m_axi_wready)  n_w  <= n_w  + 1;
        if (bus.m_axi_bvalid  && bus.m_axi_bready)  n_b  <= n_b  + 1;
        if (bus.m_axi_arvalid && bus.m_axi_arready) n_ar <= n_ar + 1;
        if (bus.m_axi_rvalid  && bus.m_axi_rready)  n_r  <= n_r  + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command at a negedge; it is captured on the following posedge
    task automatic issue(input logic wr, input logic [63:0] a, d, input logic [7:0] s);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_wstrb = s;
        @(posedge aclk);
    endtask

    // Write with per-channel ready delays and a B delay counted from the last request beat
    task automatic wr_txn(input logic [63:0] a, d, input logic [7:0] s,
                          input int aw_dly, w_dly, b_dly, input logic [1:0] br, output int lat);
        bit aw_done, w_done, b_done, aw_hs, w_hs, b_hs, got;
        int bn;
        aw_done = 0; w_done = 0; b_done = 0; got = 0; bn = 0;
        issue(1'b1, a, d, s);
        lat = 1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge aclk);
            bus.cmd_valid = 1'b0;
            if (bus.rsp_valid) begin
                got = 1;
            end else begin
                if (i == 0) begin
                    chk("aw_fixed", {bus.m_axi_awlen, bus.m_axi_awsize, bus.m_axi_awburst, bus.m_axi_wlast},
                        {8'd0, 3'd3, 2'b01, 1'b1});
                    chk("wstrb", bus.m_axi_wstrb, s);
                end
                if (!aw_done) begin
                    chk("awvalid_hold", bus.m_axi_awvalid, 1);
                    chk("awaddr_stable", bus.m_axi_awaddr, a);
                end else begin
                    chk("awvalid_drop", bus.m_axi_awvalid, 0);
                end
                if (!w_done) begin
                    chk("wvalid_hold", bus.m_axi_wvalid, 1);
                    chk("wdata_stable", bus.m_axi_wdata, d);
                end else begin
                    chk("wvalid_drop", bus.m_axi_wvalid, 0);
                end
                if (!(aw_done && w_done)) chk("bready_early", bus.m_axi_bready, 0);
                bus.m_axi_awready = !aw_done && (i >= aw_dly);
                bus.m_axi_wready  = !w_done && (i >= w_dly);
                bus.m_axi_bvalid  = 1'b0;
                if (aw_done && w_done) begin
                    bus.m_axi_bvalid = !b_done && (bn >= b_dly);
                    bus.m_axi_bresp  = br;
                    bn++;
                end
                aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
                w_hs  = bus.m_axi_wvalid && bus.m_axi_wready;
                b_hs  = bus.m_axi_bvalid && bus.m_axi_bready;
                @(posedge aclk);
                lat++;
                aw_done |= aw_hs;
                w_done  |= w_hs;
                b_done  |= b_hs;
            end
        end
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        if (!got) chk("wr_rsp_seen", bus.rsp_valid, 1);
    endtask

    // Read with an AR ready delay and an R delay counted from the AR beat
    task automatic rd_txn(input logic [63:0] a, input int ar_dly, r_dly,
                          input logic [63:0] rd, input logic [1:0] rr, output int lat);
        bit ar_done, r_done, ar_hs, r_hs, got;
        int rn;
        ar_done = 0; r_done = 0; got = 0; rn = 0;
        issue(1'b0, a, 64'd0, 8'd0);
        lat = 1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge aclk);
            bus.cmd_valid = 1'b0;
            if (bus.rsp_valid) begin
                got = 1;
            end else begin
                if (i == 0)
                    chk("ar_fixed", {bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_awvalid},
                        {8'd0, 3'd3, 2'b01, 1'b0});
                if (!ar_done) begin
                    chk("arvalid_hold", bus.m_axi_arvalid, 1);
                    chk("araddr_stable", bus.m_axi_araddr, a);
                    chk("rready_early", bus.m_axi_rready, 0);
                end else begin
                    chk("arvalid_drop", bus.m_axi_arvalid, 0);
                end
                bus.m_axi_arready = !ar_done && (i >= ar_dly);
                bus.m_axi_rvalid  = 1'b0;
                if (ar_done) begin
                    bus.m_axi_rvalid = !r_done && (rn >= r_dly);
                    bus.m_axi_rdata  = rd;
                    bus.m_axi_rresp  = rr;
                    bus.m_axi_rlast  = 1'b1;
                    rn++;
                end
                ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;
                r_hs  = bus.m_axi_rvalid && bus.m_axi_rready;
                @(posedge aclk);
                lat++;
                ar_done |= ar_hs;
                r_done  |= r_hs;
            end
        end
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        if (!got) chk("rd_rsp_seen", bus.rsp_valid, 1);
    endtask

    // Check a pending response, stall it for 'hold' cycles, then accept it
    task automatic rsp_take(input int hold, input logic [63:0] erd, input logic eerr, eto, input logic exp_idle);
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_rdata", bus.rsp_rdata, erd);
        chk("rsp_err", bus.rsp_err, eerr);
        chk("rsp_timeout", bus.rsp_timeout, eto);
        chk("cmd_ready_in_rsp", bus.cmd_ready, 0);
        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready = 1'b0;
            @(posedge aclk);
            @(negedge aclk);
            chk("rsp_hold", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.cmd_ready,
                             bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid},
                {1'b1, eerr, eto, 4'b0000});
            chk("rsp_hold_rdata", bus.rsp_rdata, erd);
        end
        bus.rsp_ready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bus.rsp_ready = 1'b0;
        chk("rsp_done", bus.rsp_valid, 0);
        chk("cmd_ready_after_rsp", bus.cmd_ready, exp_idle);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
                  bus.m_axi_bready, bus.m_axi_rready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 0);
        chk({tag, "_rdata"}, bus.rsp_rdata, 0);
    endtask

    int lat;
    int sv_aw, sv_ar, sv_b;

    initial begin
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.cmd_wstrb = '0; bus.rsp_ready = 0;
        bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_arready = 0;
        bus.m_axi_bid = '0; bus.m_axi_bresp = RESP_OKAY; bus.m_axi_buser = '0; bus.m_axi_bvalid = 0;
        bus.m_axi_rid = '0; bus.m_axi_rdata = '0; bus.m_axi_rresp = RESP_OKAY;
        bus.m_axi_rlast = 0; bus.m_axi_ruser = '0; bus.m_axi_rvalid = 0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk_all_zero("reset_outputs");
        areset = 1'b0;
        #1;
        chk("cmd_ready_after_reset", bus.cmd_ready, 1);

        // Read returning SLVERR, zero-wait slave
        rd_txn(64'h0000_0000_0200_BFF8, 0, 0, 64'h1234, RESP_SLVERR, lat);
        chk("rd_latency", lat, 3);
        rsp_take(0, 64'h1234, 1'b1, 1'b0, 1'b1);
        chk("rd_beats", {n_ar[7:0], n_r[7:0]}, {8'd1, 8'd1});

        // Write, zero-wait slave, OKAY; rdata must read back zero for a write
        wr_txn(64'h0000_0000_0C00_2000, 64'h0000_0000_DEAD_BEEF, 8'h0F, 0, 0, 0, RESP_OKAY, lat);
        chk("wr_latency", lat, 3);
        rsp_take(0, 64'h0, 1'b0, 1'b0, 1'b1);
        chk("wr_beats", {n_aw[7:0], n_w[7:0], n_b[7:0]}, {8'd1, 8'd1, 8'd1});

        // W accepted 4 cycles before AW; DECERR on B
        wr_txn(64'h0000_0000_0C00_4008, 64'h0123_4567_89AB_CDEF, 8'hFF, 4, 0, 1, RESP_DECERR, lat);
        chk("wr_skew_latency", lat, 8);
        rsp_take(0, 64'h0, 1'b1, 1'b0, 1'b1);
        chk("wr_skew_beats", {n_aw[7:0], n_w[7:0], n_b[7:0]}, {8'd2, 8'd2, 8'd2});

        // Delayed read, then rsp_ready held low for 10 cycles
        rd_txn(64'h0000_0000_0200_0000, 2, 3, 64'hA5A5_5A5A_0000_FFFF, RESP_OKAY, lat);
        chk("rd_delay_latency", lat, 8);
        sv_aw = n_aw; sv_ar = n_ar;
        rsp_take(10, 64'hA5A5_5A5A_0000_FFFF, 1'b0, 1'b0, 1'b1);
        chk("no_new_requests", {n_aw[7:0], n_ar[7:0]}, {sv_aw[7:0], sv_ar[7:0]});

        // Reset while waiting for B
        issue(1'b1, 64'h0000_0000_0C00_2004, 64'h55, 8'h01);
        @(negedge aclk);
        bus.cmd_valid = 1'b0;
        bus.m_axi_awready = 1'b1;
        bus.m_axi_wready  = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        chk("in_wr_resp", {bus.m_axi_bready, bus.m_axi_awvalid, bus.m_axi_wvalid}, 3'b100);
        sv_b = n_b;
        areset = 1'b1;
        #1;
        chk_all_zero("mid_reset_outputs");
        @(posedge aclk);
        @(negedge aclk);
        bus.m_axi_bvalid = 1'b1;
        #1;
        chk_all_zero("mid_reset_hold");
        @(posedge aclk);
        @(negedge aclk);
        bus.m_axi_bvalid = 1'b0;
        areset = 1'b0;
        #1;
        chk("post_reset", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
        chk("reset_b_ignored", n_b, sv_b);
        wr_txn(64'h0000_0000_0C00_2008, 64'h66, 8'h03, 0, 0, 0, RESP_OKAY, lat);
        chk("post_reset_latency", lat, 3);
        rsp_take(0, 64'h0, 1'b0, 1'b0, 1'b1);

`ifdef AXI_REG_INIT_TIMEOUT_EN
        // B delayed 20 cycles: timeout after 8 wait cycles, then drain the late beat
        begin
            int w;
            bit got;
            issue(1'b1, 64'h0000_0000_0C00_200C, 64'h77, 8'h0F);
            @(negedge aclk);
            bus.cmd_valid = 1'b0;
            bus.m_axi_awready = 1'b1;
            bus.m_axi_wready  = 1'b1;
            @(posedge aclk);
            @(negedge aclk);
            bus.m_axi_awready = 1'b0;
            bus.m_axi_wready  = 1'b0;
            w = 0; got = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                if (bus.rsp_valid) begin
                    got = 1;
                end else begin
                    chk("bready_wait", bus.m_axi_bready, 1);
                    @(posedge aclk);
                    w++;
                    @(negedge aclk);
                end
            end
            chk("timeout_cycles", w, 8);
            sv_b = n_b;
            rsp_take(2, 64'h0, 1'b1, 1'b1, 1'b0);
            for (int k = 0; k < 9; k++) begin
                chk("drain_wait", {bus.m_axi_bready, bus.cmd_ready, bus.rsp_valid}, 3'b100);
                @(posedge aclk);
                @(negedge aclk);
            end
            bus.m_axi_bresp  = RESP_OKAY;
            bus.m_axi_bvalid = 1'b1;
            @(posedge aclk);
            @(negedge aclk);
            bus.m_axi_bvalid = 1'b0;
            chk("drain_done", {bus.cmd_ready, bus.m_axi_bready, bus.rsp_valid}, 3'b100);
            chk("drain_one_beat", n_b, sv_b + 1);
        end

        // B arriving in the timeout cycle itself wins over the timeout
        wr_txn(64'h0000_0000_0C00_2010, 64'h88, 8'h0F, 0, 0, 7, RESP_OKAY, lat);
        chk("beat_wins_latency", lat, 10);
        rsp_take(0, 64'h0, 1'b0, 1'b0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound on simulation time
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/axi_reg_initiator.md
AXI_REG_INITIATOR -- requirements
Module: axi_reg_initiator

Interface
REQ-001 Parameter AXI_ID_WIDTH, default 10: width of AWID/ARID/BID/RID.
REQ-002 Parameter AXI_ADDR_WIDTH, default 64: width of AWADDR/ARADDR and cmd_addr.
REQ-003 Parameter AXI_DATA_WIDTH, default 64: width of WDATA/RDATA, cmd_wdata and rsp_rdata.
REQ-004 Parameter AXI_USER_WIDTH, default 1: width of the user fields, all driven 0.
REQ-005 Parameter AXI_ID, default 0: constant AWID/ARID value.
REQ-006 Parameter TIMEOUT_CYCLES, default 1024: response-wait limit, 1..2^16-1.
REQ-007 aclk  in  1  sole clock; all logic on its rising edge.
REQ-008 areset  in  1  asynchronous, active-high reset.
REQ-009 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-010 cmd_write  in  1  1 = write, 0 = read.
REQ-011 cmd_addr, cmd_wdata, cmd_wstrb  in  ADDR/DATA/DATA/8  access address, write data and byte strobes.
REQ-012 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-013 rsp_rdata, rsp_err, rsp_timeout  out  DATA/1/1  read data; 1 = SLVERR/DECERR; 1 = timeout.
REQ-014 m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  AXI4 master ports  standard widths  single-beat initiator toward the PLIC/Timer slave ports.

Function
REQ-015 States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DRAIN, RSP.
REQ-016 cmd_ready = 1 only in IDLE; the command is captured on cmd_valid&&cmd_ready.
REQ-017 IDLE -> WR_REQ (cmd_write=1) or RD_REQ; awvalid+wvalid, or arvalid, assert on the next cycle.
REQ-018 Fixed fields: len 0, size log2(DATA/8), burst INCR, wlast 1, cache/prot/qos/lock/region 0.
REQ-019 WR_REQ: awvalid and wvalid are independent; each drops after its own handshake; both handshakes, in either order or together, -> WR_RESP.
REQ-020 Valid signals never drop before their handshake, and address/data stay stable while valid.
REQ-021 WR_RESP: bready = 1; B handshake -> RSP with rsp_err = bresp[1].
REQ-022 RD_REQ: AR handshake -> RD_RESP; rready = 1; R handshake -> RSP, rsp_rdata = rdata, rsp_err = rresp[1].
REQ-023 RSP: rsp_valid = 1 with stable fields until rsp_ready, then -> IDLE; minimum command-to-rsp_valid latency is 3 cycles with zero-wait slaves.
REQ-024 rsp_rdata = 0 for writes; rsp_timeout = 0 except as in REQ-030.
REQ-025 B/R beats arriving outside WR_RESP/RD_RESP/DRAIN are never accepted: bready = rready = 0 there.

Reset
REQ-026 While areset is high: state IDLE, every valid/ready output 0 (including cmd_ready), rsp fields 0, timeout counter 0.
REQ-027 Reset mid-transaction abandons it with no response; cmd_ready rises in the first cycle after areset falls.

Configuration
REQ-028 Macro AXI_REG_INIT_TIMEOUT_EN compiles in a 16-bit response-wait counter.
REQ-029 The counter clears on entry to WR_RESP/RD_RESP and increments each cycle there.
REQ-030 When the counter reaches TIMEOUT_CYCLES: -> RSP with rsp_err = 1, rsp_timeout = 1; after rsp_ready -> DRAIN.
REQ-031 DRAIN holds bready (or rready) at 1, discards exactly one late beat, then -> IDLE.
REQ-032 If the late beat coincides with the timeout cycle, the beat wins: normal response, no DRAIN.
REQ-033 Without the macro: no counter, no DRAIN, rsp_timeout tied 0, waits unbounded.

Structure
REQ-034 State enum and the resp-code constants (OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11) live in package axi_reg_init_pkg.
REQ-035 One sub-module, axi_reg_init_timeout (counter plus compare), is instantiated only under the macro.

Verification
REQ-036 Write 0x0C00_2000 / data 0xDEAD_BEEF / strb 0x0F, slave ready immediately, bresp OKAY -> one AW and one W beat, rsp_valid 3 cycles after the command, err 0.
REQ-037 wready 4 cycles before awready -> wvalid drops after its beat, awvalid holds until accepted, exactly one B accepted.
REQ-038 Read 0x0200_BFF8 returning rdata 0x1234 with rresp SLVERR -> rsp_rdata 0x1234, rsp_err 1.
REQ-039 rsp_ready held low 10 cycles -> rsp fields stable, cmd_ready 0 throughout, no new AR/AW issued.
REQ-040 Macro on, TIMEOUT_CYCLES = 8, B delayed 20 cycles -> rsp_timeout 1 at wait cycle 8, late B drained, then IDLE.
REQ-041 areset pulsed while in WR_RESP -> all outputs 0 during reset, no rsp_valid, next command completes normally.
